// File: rtl/kb_pkg.sv
// Shared definitions for the keyboard-to-serial path: scan codes, ASCII constants, state encodings.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package kb_pkg;

  // PS/2 set-2 scan codes with special meaning to the parser
  localparam logic [7:0] SC_BREAK  = 8'hF0;
  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;

  localparam logic [7:0] ASC_SPACE = 8'h20;
  localparam logic [7:0] ASC_CR    = 8'h0D;
  localparam logic [7:0] ASC_UNK   = 8'h2A;

  typedef enum logic [1:0] {
    P_IDLE,
    P_BRK,
    P_EXT,
    P_EXTBRK
  } p_state_t;

  typedef enum logic {
    TX_IDLE,
    TX_BUSY
  } tx_state_t;

  function automatic logic is_shift_code(input logic [7:0] code);
    return (code == SC_LSHIFT) || (code == SC_RSHIFT);
  endfunction

endpackage

// File: rtl/kb_code2ascii.sv
// Scan-code to ASCII translation for digits, letters (Shift selects case), space and CR.
// Latency: purely combinational.
// Backpressure: none; no handshake.
// Ports: code (set-2 scan code), shift (current Shift state), ascii (translated byte,
//        unk_char for any code without a mapping).
module kb_code2ascii
  import kb_pkg::*;
#(
  parameter logic [7:0] UNK_CHAR = ASC_UNK
) (
  input  logic [7:0] code,
  input  logic       shift,
  output logic [7:0] ascii
);

  // Letter index 0..25 for A..Z; 63 means "not a letter"
  logic [5:0] letter;

  always_comb begin
    ascii  = UNK_CHAR;
    letter = 6'd63;
    case (code)
      8'h45: ascii = 8'h30;
      8'h16: ascii = 8'h31;
      8'h1E: ascii = 8'h32;
      8'h26: ascii = 8'h33;
      8'h25: ascii = 8'h34;
      8'h2E: ascii = 8'h35;
      8'h36: ascii = 8'h36;
      8'h3D: ascii = 8'h37;
      8'h3E: ascii = 8'h38;
      8'h46: ascii = 8'h39;
      8'h29: ascii = ASC_SPACE;
      8'h5A: ascii = ASC_CR;
      8'h1C: letter = 6'd0;
      8'h32: letter = 6'd1;
      8'h21: letter = 6'd2;
      8'h23: letter = 6'd3;
      8'h24: letter = 6'd4;
      8'h2B: letter = 6'd5;
      8'h34: letter = 6'd6;
      8'h33: letter = 6'd7;
      8'h43: letter = 6'd8;
      8'h3B: letter = 6'd9;
      8'h42: letter = 6'd10;
      8'h4B: letter = 6'd11;
      8'h3A: letter = 6'd12;
      8'h31: letter = 6'd13;
      8'h44: letter = 6'd14;
      8'h4D: letter = 6'd15;
      8'h15: letter = 6'd16;
      8'h2D: letter = 6'd17;
      8'h1B: letter = 6'd18;
      8'h2C: letter = 6'd19;
      8'h3C: letter = 6'd20;
      8'h2A: letter = 6'd21;
      8'h1D: letter = 6'd22;
      8'h22: letter = 6'd23;
      8'h35: letter = 6'd24;
      8'h1A: letter = 6'd25;
      default: ;
    endcase
    if (letter != 6'd63)
      ascii = (shift ? 8'h41 : 8'h61) + {2'b00, letter};
  end

endmodule

// File: rtl/kb_event_ctrl.sv
// Scan-code parser + character FIFO + UART start/done sequencer for the keyboard-to-serial path.
// Latency: key release byte at cycle N -> FIFO write at N+1 -> tx_start at N+2 when the UART is idle.
// Backpressure: UART busy holds characters in the FIFO; a character arriving on a full FIFO is dropped and flags overflow.
// Ports: clk/reset (async active-low); rx_done_tick/rx_data from the PS/2 receiver;
//        tx_start/tx_data/tx_done_tick to/from the UART; shift_o, fifo_count, overflow status; clr_overflow.
module kb_event_ctrl
  import kb_pkg::*;
#(
  parameter int         FIFO_AW  = 2,
  parameter logic [7:0] UNK_CHAR = ASC_UNK
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               rx_done_tick,
  input  logic [7:0]         rx_data,
  input  logic               tx_done_tick,
  output logic               tx_start,
  output logic [7:0]         tx_data,
  output logic               shift_o,
  output logic [FIFO_AW:0]   fifo_count,
  output logic               overflow,
  input  logic               clr_overflow
);

  localparam int               DEPTH    = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] FULL_CNT = (FIFO_AW + 1)'(DEPTH);

  p_state_t     p_state;
  tx_state_t    tx_state;
  logic         shift_q;
  logic         emit_vld;
  logic [7:0]   emit_dat;
  logic [7:0]   ascii_w;

  logic [7:0]          mem [DEPTH];
  logic [FIFO_AW-1:0]  wr_ptr;
  logic [FIFO_AW-1:0]  rd_ptr;
  logic [FIFO_AW:0]    cnt;
  logic                full;
  logic                pop;
  logic                push_ok;

  // Translation uses the Shift state at the moment the break code arrives
  kb_code2ascii #(.UNK_CHAR(UNK_CHAR)) u_code2ascii (
    .code  (rx_data),
    .shift (shift_q),
    .ascii (ascii_w)
  );

  // Parser: only key releases emit; make codes other than Shift are ignored
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      p_state  <= P_IDLE;
      shift_q  <= 1'b0;
      emit_vld <= 1'b0;
      emit_dat <= 8'h00;
    end else begin
      emit_vld <= 1'b0;
      if (rx_done_tick) begin
        case (p_state)
          P_IDLE: begin
            if (rx_data == SC_BREAK)         p_state <= P_BRK;
            else if (rx_data == SC_EXT)      p_state <= P_EXT;
            else if (is_shift_code(rx_data)) shift_q <= 1'b1;
          end
          P_BRK: begin
            // A repeated F0 keeps waiting for the real code
            if (rx_data != SC_BREAK) begin
              p_state <= P_IDLE;
              if (is_shift_code(rx_data)) begin
                shift_q <= 1'b0;
              end else begin
                emit_vld <= 1'b1;
                emit_dat <= ascii_w;
              end
            end
          end
          P_EXT: begin
            if (rx_data == SC_BREAK) p_state <= P_EXTBRK;
            else                     p_state <= P_IDLE;
          end
          P_EXTBRK: begin
            if (rx_data != SC_BREAK) p_state <= P_IDLE;
          end
          default: p_state <= P_IDLE;
        endcase
      end
    end
  end

  // FIFO: a pop in the same cycle frees the slot, so a push on full still lands
  assign full    = (cnt == FULL_CNT);
  assign pop     = (tx_state == TX_IDLE) && (cnt != '0);
  assign push_ok = emit_vld && (!full || pop);

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= emit_dat;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      cnt      <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + FIFO_AW'(1);
      if (pop)     rd_ptr <= rd_ptr + FIFO_AW'(1);
      case ({push_ok, pop})
        2'b10:   cnt <= cnt + (FIFO_AW + 1)'(1);
        2'b01:   cnt <= cnt - (FIFO_AW + 1)'(1);
        default: ;
      endcase
      // A new drop takes priority over a clear in the same cycle
      if (emit_vld && !push_ok) overflow <= 1'b1;
      else if (clr_overflow)    overflow <= 1'b0;
    end
  end

  // Tx sequencer: pop and tx_start happen together, tx_data stays until the next pop
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_state <= TX_IDLE;
      tx_start <= 1'b0;
      tx_data  <= 8'h00;
    end else begin
      tx_start <= 1'b0;
      case (tx_state)
        TX_IDLE: begin
          if (pop) begin
            tx_data  <= mem[rd_ptr];
            tx_start <= 1'b1;
            tx_state <= TX_BUSY;
          end
        end
        TX_BUSY: begin
          if (tx_done_tick) tx_state <= TX_IDLE;
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  assign shift_o    = shift_q;
  assign fifo_count = cnt;

endmodule

// File: tb/tb_kb_event_ctrl.sv
// Bench for kb_event_ctrl: vector table, directed corner cases, random byte stream vs reference model.
// Latency: n/a.
// Backpressure: UART responder can hold tx_done_tick off to fill the FIFO.
module tb_kb_event_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       rx_done_tick = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       tx_done_tick = 1'b0;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       shift_o;
  logic [2:0] fifo_count;
  logic       overflow;
  logic       clr_overflow = 1'b0;

  kb_event_ctrl #(.FIFO_AW(2), .UNK_CHAR(8'h2A)) dut (
    .clk          (clk),
    .reset        (reset),
    .rx_done_tick (rx_done_tick),
    .rx_data      (rx_data),
    .tx_done_tick (tx_done_tick),
    .tx_start     (tx_start),
    .tx_data      (tx_data),
    .shift_o      (shift_o),
    .fifo_count   (fifo_count),
    .overflow     (overflow),
    .clr_overflow (clr_overflow)
  );

  always #5 clk = ~clk;

  int ncmp = 0;
  int nfail = 0;

  logic [7:0] got [$];
  logic [7:0] exp_q [$];

  // UART responder
  int  done_delay = 10;
  bit  hold_done  = 1'b0;
  bit  pending    = 1'b0;
  int  dcnt       = 0;

  always begin
    @(posedge clk);
    #1;
    tx_done_tick = 1'b0;
    if (!reset) begin
      pending = 1'b0;
    end else if (tx_start) begin
      pending = 1'b1;
      dcnt    = done_delay;
    end else if (pending && !hold_done) begin
      if (dcnt <= 1) begin
        tx_done_tick = 1'b1;
        pending      = 1'b0;
      end else begin
        dcnt = dcnt - 1;
      end
    end
  end

  always begin
    @(posedge clk);
    #1;
    if (reset && tx_start) got.push_back(tx_data);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int req);
    ncmp++;
    if (act != req) begin
      nfail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_data      = b;
    rx_done_tick = 1'b1;
    tick();
    rx_done_tick = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    tick();
    got.delete();
  endtask

  // Reference model: prefix flags and a Shift flag, ASCII by table lookup
  localparam logic [7:0] DIG [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
  localparam logic [7:0] LET [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                                      8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                                      8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};

  function automatic logic [7:0] ref_ascii(input logic [7:0] c, input bit sh);
    for (int i = 0; i < 10; i++) if (DIG[i] == c) return 8'h30 + 8'(i);
    for (int i = 0; i < 26; i++) if (LET[i] == c) return (sh ? 8'h41 : 8'h61) + 8'(i);
    if (c == 8'h29) return 8'h20;
    if (c == 8'h5A) return 8'h0D;
    return 8'h2A;
  endfunction

  bit m_brk = 0, m_ext = 0, m_shift = 0;

  task automatic model_byte(input logic [7:0] b);
    bit is_sh;
    is_sh = (b == 8'h12) || (b == 8'h59);
    if (b == 8'hF0) begin
      m_brk = 1;
    end else if (!m_ext && !m_brk && b == 8'hE0) begin
      m_ext = 1;
    end else begin
      if (!m_ext) begin
        if (m_brk) begin
          if (is_sh) m_shift = 0;
          else       exp_q.push_back(ref_ascii(b, m_shift));
        end else if (is_sh) begin
          m_shift = 1;
        end
      end
      m_brk = 0;
      m_ext = 0;
    end
  endtask

  typedef struct {
    logic [5:0][7:0] b;
    int              n;
    int              exp_n;
    logic [7:0]      exp_ch;
    logic            exp_sh;
  } vec_t;

  vec_t vt [13];

  localparam logic [7:0] POOL [12] = '{8'h45, 8'h16, 8'h46, 8'h1C, 8'h1A, 8'h4D, 8'h29,
                                       8'h5A, 8'h76, 8'h75, 8'h3E, 8'h2B};

  initial begin
    vt[0]  = '{48'h45F045000000, 3, 1, 8'h30, 1'b0};
    vt[1]  = '{48'h121CF01C0000, 4, 1, 8'h41, 1'b1};
    vt[2]  = '{48'hF01200000000, 2, 0, 8'h00, 1'b0};
    vt[3]  = '{48'h1CF01C000000, 3, 1, 8'h61, 1'b0};
    vt[4]  = '{48'hE075E0F07500, 5, 0, 8'h00, 1'b0};
    vt[5]  = '{48'h29F029000000, 3, 1, 8'h20, 1'b0};
    vt[6]  = '{48'hF07600000000, 2, 1, 8'h2A, 1'b0};
    vt[7]  = '{48'hF0F045000000, 3, 1, 8'h30, 1'b0};
    vt[8]  = '{48'hF05A00000000, 2, 1, 8'h0D, 1'b0};
    vt[9]  = '{48'h59F01AF05900, 5, 1, 8'h5A, 1'b0};
    vt[10] = '{48'hF04D00000000, 2, 1, 8'h70, 1'b0};
    vt[11] = '{48'hF0E000000000, 2, 1, 8'h2A, 1'b0};
    vt[12] = '{48'hF04600000000, 2, 1, 8'h39, 1'b0};

    // Reset values, checked while reset is held and after release
    reset = 1'b0;
    repeat (2) tick();
    chk("rst_tx_start", tx_start, 0);
    chk("rst_tx_data", tx_data, 8'h00);
    chk("rst_shift", shift_o, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_overflow", overflow, 0);
    reset = 1'b1;
    tick();
    chk("rel_tx_start", tx_start, 0);
    chk("rel_count", fifo_count, 0);

    // Vector table
    done_delay = 10;
    for (int v = 0; v < 13; v++) begin
      got.delete();
      for (int i = 0; i < vt[v].n; i++) send_byte(vt[v].b[5 - i], 3);
      repeat (30) tick();
      chk($sformatf("vec%0d_nchars", v), got.size(), vt[v].exp_n);
      if (vt[v].exp_n > 0 && got.size() > 0) chk($sformatf("vec%0d_char", v), got[0], vt[v].exp_ch);
      chk($sformatf("vec%0d_shift", v), shift_o, vt[v].exp_sh);
      chk($sformatf("vec%0d_count", v), fifo_count, 0);
    end

    // Emit latency: rx tick at edge N, FIFO write at N+1, tx_start at N+2
    got.delete();
    send_byte(8'hF0, 2);
    rx_data      = 8'h45;
    rx_done_tick = 1'b1;
    tick();
    rx_done_tick = 1'b0;
    chk("lat_n0_start", tx_start, 0);
    chk("lat_n0_count", fifo_count, 0);
    tick();
    chk("lat_n1_start", tx_start, 0);
    chk("lat_n1_count", fifo_count, 1);
    tick();
    chk("lat_n2_start", tx_start, 1);
    chk("lat_n2_data", tx_data, 8'h30);
    chk("lat_n2_count", fifo_count, 0);
    tick();
    chk("lat_pulse_width", tx_start, 0);
    repeat (15) tick();
    chk("tx_data_hold", tx_data, 8'h30);
    chk("lat_nchars", got.size(), 1);

    // Overflow with UART stalled
    got.delete();
    hold_done = 1'b1;
    send_byte(8'hF0, 2); send_byte(8'h16, 2);
    send_byte(8'hF0, 2); send_byte(8'h1E, 2);
    send_byte(8'hF0, 2); send_byte(8'h26, 2);
    send_byte(8'hF0, 2); send_byte(8'h25, 2);
    send_byte(8'hF0, 2); send_byte(8'h2E, 2);
    send_byte(8'hF0, 2); send_byte(8'h36, 2);
    repeat (5) tick();
    chk("ovf_count", fifo_count, 4);
    chk("ovf_flag", overflow, 1);
    chk("ovf_inflight_n", got.size(), 1);
    if (got.size() > 0) chk("ovf_inflight_ch", got[0], 8'h31);
    clr_overflow = 1'b1;
    tick();
    clr_overflow = 1'b0;
    chk("ovf_clear", overflow, 0);
    // Drop and clear in the same cycle: set wins
    send_byte(8'hF0, 2);
    rx_data      = 8'h3D;
    rx_done_tick = 1'b1;
    tick();
    rx_done_tick = 1'b0;
    clr_overflow = 1'b1;
    tick();
    clr_overflow = 1'b0;
    chk("ovf_set_wins", overflow, 1);
    chk("ovf_count_full", fifo_count, 4);
    clr_overflow = 1'b1;
    tick();
    clr_overflow = 1'b0;
    chk("ovf_clear2", overflow, 0);
    hold_done = 1'b0;
    repeat (80) tick();
    chk("drain_n", got.size(), 5);
    for (int i = 0; i < 5; i++)
      if (i < got.size()) chk($sformatf("drain_ch%0d", i), got[i], 8'h31 + 8'(i));
    chk("drain_count", fifo_count, 0);
    chk("drain_ovf", overflow, 0);

    // Reset mid-operation
    hold_done = 1'b1;
    send_byte(8'h12, 2);
    send_byte(8'hF0, 2); send_byte(8'h16, 2);
    send_byte(8'hF0, 2); send_byte(8'h1E, 2);
    send_byte(8'hF0, 2); send_byte(8'h26, 2);
    repeat (5) tick();
    chk("mid_count", fifo_count, 2);
    chk("mid_shift", shift_o, 1);
    reset = 1'b0;
    #1;
    chk("arst_tx_start", tx_start, 0);
    chk("arst_count", fifo_count, 0);
    chk("arst_shift", shift_o, 0);
    chk("arst_tx_data", tx_data, 8'h00);
    repeat (2) @(posedge clk);
    #1;
    reset     = 1'b1;
    hold_done = 1'b0;
    got.delete();
    tick();
    chk("post_rst_count", fifo_count, 0);
    chk("post_rst_start", tx_start, 0);
    send_byte(8'h45, 3); send_byte(8'hF0, 3); send_byte(8'h45, 3);
    repeat (30) tick();
    chk("post_rst_n", got.size(), 1);
    if (got.size() > 0) chk("post_rst_ch", got[0], 8'h30);

    // Random byte stream against the reference model
    do_reset();
    exp_q.delete();
    m_brk = 0; m_ext = 0; m_shift = 0;
    done_delay = 2;
    for (int k = 0; k < 300; k++) begin
      logic [7:0] b;
      int r;
      r = $urandom_range(0, 9);
      if (r <= 2)      b = 8'hF0;
      else if (r == 3) b = 8'hE0;
      else if (r == 4) b = ($urandom_range(0, 1) == 1) ? 8'h12 : 8'h59;
      else if (r == 5) b = 8'($urandom_range(0, 255));
      else             b = POOL[$urandom_range(0, 11)];
      model_byte(b);
      send_byte(b, 3);
    end
    repeat (60) tick();
    chk("rnd_nchars", got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (i < got.size()) chk($sformatf("rnd_ch%0d", i), got[i], exp_q[i]);
    chk("rnd_shift", shift_o, m_shift);
    chk("rnd_ovf", overflow, 0);
    chk("rnd_count", fifo_count, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
